// File: rtl/svnseg_pkg.sv
// Shared types and the hex-to-seven-segment table for the scan controller.
// Segment patterns are active-high {a,b,c,d,e,f,g}; bit 6 = a.
package svnseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF   = 7'h00;
  localparam int    PWM_STEPS = 16;

  localparam seg7_t HEX_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/svnseg_scan_controller_if.sv
// Display bus: register-side inputs (nums/dps/enable/brightness) and pin-side
// outputs. master = value source / pin observer, slave = the scan controller.
interface svnseg_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] nums;
  logic [NUM_DIGITS-1:0]   dps;
  logic                    enable;
  logic [3:0]              brightness;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   dig;
  logic [6:0]              seg;
  logic                    dp;

  modport master (output nums, dps, enable, brightness,
                  input  frame_start, dig, seg, dp);
  modport slave  (input  nums, dps, enable, brightness,
                  output frame_start, dig, seg, dp);
endinterface

// File: rtl/num_to_svnseg.sv
// Combinational hex nibble to active-high seven-segment decoder.
module num_to_svnseg
  import svnseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/svnseg_scan_controller.sv
// Time-multiplexed seven-segment scanner with frame-coherent snapshots,
// PWM brightness, live enable and a one-cycle blank between digit slots.
// Optional: define SVNSEG_LZ_BLANK_EN for leading-zero blanking.
module svnseg_scan_controller
  import svnseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 4096,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  svnseg_scan_controller_if.slave bus
);
  localparam int PW     = $clog2(SCAN_DIV);
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam int PH_DIV = SCAN_DIV / PWM_STEPS;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = {NUM_DIGITS{1'(DIG_ACTIVE_LOW)}};
  localparam seg7_t                 SEG_IDLE = SEG_ACTIVE_LOW != 0 ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_IDLE  = 1'(SEG_ACTIVE_LOW);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_nums_q, sh_nums_d;
  logic [NUM_DIGITS-1:0]   sh_dps_q, sh_dps_d;
  logic [3:0]              sh_br_q, sh_br_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  seg7_t                   seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_tick, snap, drive_on, blank, dp_bit;
  logic [3:0]              phase, nibble;
  seg7_t                   seg_dec;
  logic [NUM_DIGITS-1:0]   dig_a;
  seg7_t                   seg_a;
  logic                    dp_a;

  // Single decoder on the currently scanned shadow nibble.
  num_to_svnseg u_dec (.nibble(nibble), .seg(seg_dec));

`ifdef SVNSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_q, lz_d, lz_new;
  logic                  run;

  // Blank mask: digit i blanked when it and every digit above it are zero.
  always_comb begin
    lz_new = '0;
    run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run       = run & (bus.nums[4*i +: 4] == 4'h0);
      lz_new[i] = run;
    end
    lz_d = snap ? lz_new : lz_q;
  end

  // Blank mask is captured together with the value snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lz_q <= '0;
    else        lz_q <= lz_d;
  end

  assign blank = lz_q[idx_q];
`else
  assign blank = 1'b0;
`endif

  // Scan timing, snapshot and pin drive for the next cycle.
  always_comb begin
    slot_tick = presc_q == PW'(SCAN_DIV - 1);
    snap      = slot_tick && (idx_q == IW'(NUM_DIGITS - 1));
    phase     = 4'(presc_q / PW'(PH_DIV));

    presc_d = slot_tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    sh_nums_d     = snap ? bus.nums       : sh_nums_q;
    sh_dps_d      = snap ? bus.dps        : sh_dps_q;
    sh_br_d       = snap ? bus.brightness : sh_br_q;
    frame_start_d = snap;

    nibble   = sh_nums_q[{idx_q, 2'b00} +: 4];
    dp_bit   = sh_dps_q[idx_q];
    // Tick cycle is forced dark to leave one blank cycle between digits.
    drive_on = bus.enable && (phase < sh_br_q) && !slot_tick;

    dig_a = (drive_on && (!blank || dp_bit))
            ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q) : '0;
    seg_a = (drive_on && !blank) ? seg_dec : SEG_OFF;
    dp_a  = drive_on && dp_bit;

    dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_a : dig_a;
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_a : seg_a;
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_a  : dp_a;
  end

  // State and registered pins; pins idle at their inactive level in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      sh_nums_q     <= '0;
      sh_dps_q      <= '0;
      sh_br_q       <= '0;
      frame_start_q <= 1'b0;
      dig_q         <= DIG_IDLE;
      seg_q         <= SEG_IDLE;
      dp_q          <= DP_IDLE;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      sh_nums_q     <= sh_nums_d;
      sh_dps_q      <= sh_dps_d;
      sh_br_q       <= sh_br_d;
      frame_start_q <= frame_start_d;
      dig_q         <= dig_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.dig         = dig_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;

endmodule

// File: tb/tb_svnseg_scan_controller.sv
// Randomised bench for svnseg_scan_controller against a cycle-count model:
// slot, phase and frame are derived arithmetically from cycles since reset.
module tb_svnseg_scan_controller;
  localparam int N      = 4;
  localparam int SD     = 32;
  localparam int FRAME  = N * SD;
  localparam int SEG_AL = 1;
  localparam int DIG_AL = 1;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  svnseg_scan_controller_if #(.NUM_DIGITS(N)) bus();

  svnseg_scan_controller #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(SEG_AL), .DIG_ACTIVE_LOW(DIG_AL)
  ) dut (
    .clk(gclk), .rst_n(grst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  int lit_cnt = 0;

  logic [4*N-1:0] sh_nums;
  logic [N-1:0]   sh_dps, sh_lz;
  logic [3:0]     sh_br;
  logic [N-1:0]   exp_dig;
  logic [6:0]     exp_seg;
  logic           exp_dp, exp_fs;

  logic [4*N-1:0] cur_nums;
  logic [N-1:0]   cur_dps;
  logic [3:0]     cur_br;
  logic           cur_en;

  localparam logic [N-1:0] DIG_IDLE = (DIG_AL != 0) ? '1 : '0;
  localparam logic [6:0]   SEG_IDLE = (SEG_AL != 0) ? 7'h7F : 7'h00;
  localparam logic         DP_IDLE  = (SEG_AL != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  task automatic model_reset();
    t = 0; sh_nums = '0; sh_dps = '0; sh_br = '0; sh_lz = '0;
    exp_dig = DIG_IDLE; exp_seg = SEG_IDLE; exp_dp = DP_IDLE; exp_fs = 1'b0;
  endtask

  // Apply inputs, predict the pins after the next edge, then check at negedge.
  task automatic step(input logic [4*N-1:0] n, input logic [N-1:0] d,
                      input logic [3:0] b, input logic e);
    int p, s, ph, hi;
    logic on, bl, dpb;
    logic [N-1:0] dig_a;
    logic [6:0]   seg_a;
    bus.nums = n; bus.dps = d; bus.brightness = b; bus.enable = e;
    p   = t % SD;
    s   = (t / SD) % N;
    ph  = p / (SD / 16);
    on  = e && (ph < int'(sh_br)) && (p != SD - 1);
`ifdef SVNSEG_LZ_BLANK_EN
    bl  = sh_lz[s];
`else
    bl  = 1'b0;
`endif
    dpb = sh_dps[s];
    dig_a = (on && (!bl || dpb)) ? N'(1 << s) : '0;
    seg_a = (on && !bl) ? ref_seg(sh_nums[s*4 +: 4]) : 7'h00;
    exp_dig = (DIG_AL != 0) ? ~dig_a : dig_a;
    exp_seg = (SEG_AL != 0) ? ~seg_a : seg_a;
    exp_dp  = (SEG_AL != 0) ? ~(on && dpb) : (on && dpb);
    exp_fs  = (t % FRAME) == FRAME - 1;
    if (exp_fs) begin
      sh_nums = n; sh_dps = d; sh_br = b;
      hi = 0;
      for (int i = 0; i < N; i++) if (n[i*4 +: 4] != 4'h0) hi = i;
      for (int i = 0; i < N; i++) sh_lz[i] = (i > hi);
    end
    t++;
    @(negedge gclk);
    chk("dig", 32'(bus.dig), 32'(exp_dig));
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("dp",  32'(bus.dp),  32'(exp_dp));
    chk("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    if (bus.dig != DIG_IDLE) lit_cnt++;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step(cur_nums, cur_dps, cur_br, cur_en);
  endtask

  initial begin
    cur_nums = '0; cur_dps = '0; cur_br = '0; cur_en = 1'b0;
    bus.nums = '0; bus.dps = '0; bus.brightness = '0; bus.enable = 1'b0;
    model_reset();
    repeat (3) @(negedge gclk);
    chk("rst_dig", 32'(bus.dig), 32'(DIG_IDLE));
    chk("rst_seg", 32'(bus.seg), 32'(SEG_IDLE));
    chk("rst_fs",  32'(bus.frame_start), 32'h0);
    grst_n = 1'b1;

    // Fixed value at full duty, then a mid-frame value change.
    cur_nums = 16'h1234; cur_br = 4'd15; cur_en = 1'b1;
    run(2 * FRAME + SD + 7);
    cur_nums = 16'h5678;
    run(2 * FRAME);

    // PWM: brightness 4 lights 8 of 32 cycles per slot.
    cur_nums = 16'h8421; cur_br = 4'd4;
    run(2 * FRAME);
    lit_cnt = 0;
    run(FRAME);
    chk("pwm4_lit", 32'(lit_cnt), 32'(N * 8));
    cur_br = 4'd0;
    run(2 * FRAME);
    lit_cnt = 0;
    run(3 * FRAME);
    chk("pwm0_lit", 32'(lit_cnt), 32'h0);

    // Enable dropped for 50 cycles mid-slot; scanning keeps going.
    cur_br = 4'd15; cur_dps = 4'b0101;
    run(FRAME + 13);
    cur_en = 1'b0;
    run(50);
    cur_en = 1'b1;
    run(FRAME);

    // Leading-zero patterns (plain display without the blanking build).
    cur_nums = 16'h0040; cur_dps = 4'b1000;
    run(2 * FRAME);
    cur_nums = 16'h0000; cur_dps = 4'b0000;
    run(2 * FRAME);

    // Random inputs.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 39) == 0) cur_nums = 16'($urandom);
      if ($urandom_range(0, 39) == 0) cur_dps  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) cur_br   = 4'($urandom);
      if ($urandom_range(0, 29) == 0) cur_en   = ~cur_en;
      if ($urandom_range(0, 99) == 0) cur_nums = 16'h0000 | (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
      step(cur_nums, cur_dps, cur_br, cur_en);
    end

    // Asynchronous reset mid-slot, then resume.
    cur_en = 1'b1; cur_br = 4'd15; cur_nums = 16'h9ABC;
    run(FRAME + 17);
    #2 grst_n = 1'b0;
    #1;
    chk("arst_dig", 32'(bus.dig), 32'(DIG_IDLE));
    chk("arst_seg", 32'(bus.seg), 32'(SEG_IDLE));
    chk("arst_dp",  32'(bus.dp),  32'(DP_IDLE));
    chk("arst_fs",  32'(bus.frame_start), 32'h0);
    repeat (2) @(negedge gclk);
    model_reset();
    grst_n = 1'b1;
    run(3 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
